// File: rtl/ysyx_25040111_csr_seq.sv
// CSR access sequencer: issues ordered CSR file read/write/jtype cycles for CSRR*, ECALL and MRET.
// Optional build macro YSYX_25040111_CSR_ZEROSKIP_EN skips the write-back for CSRRS/CSRRC with src==0.
module ysyx_25040111_csr_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [11:0] in_addr,
   input  logic [31:0] in_src,
   input  logic [31:0] in_pc,
   output logic        csr_wen,
   output logic        csr_ren,
   output logic [11:0] csr_waddr,
   output logic [11:0] csr_raddr,
   output logic [31:0] csr_wdata,
   output logic [1:0]  csr_jtype,
   input  logic [31:0] csr_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rdata,
   output logic        out_redirect,
   output logic [31:0] out_npc,
   output logic        out_err
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned OP_W   = 3;

   localparam logic [OP_W-1:0]   OP_RW    = 3'b000;
   localparam logic [OP_W-1:0]   OP_RS    = 3'b001;
   localparam logic [OP_W-1:0]   OP_RC    = 3'b010;
   localparam logic [OP_W-1:0]   OP_ECALL = 3'b011;
   localparam logic [OP_W-1:0]   OP_MRET  = 3'b100;
   localparam logic [ADDR_W-1:0] A_MEPC   = 12'h341;
   localparam logic [ADDR_W-1:0] A_MTVEC  = 12'h305;
   localparam logic [1:0]        JT_ECALL = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_WRITE, S_EPC, S_VEC, S_RET, S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [OP_W-1:0]   op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   src_q, pc_q, old_q, old_d;

   logic              wen_d, ren_d;
   logic [ADDR_W-1:0] waddr_d, raddr_d;
   logic [XLEN-1:0]   wdata_d;
   logic [1:0]        jtype_d;
   logic              valid_d, redir_d, err_d;
   logic [XLEN-1:0]   rdata_d, npc_d;
   logic              accept, skip;

   assign in_ready = (state_q == S_IDLE) & reset;
   assign accept   = in_valid & in_ready;

`ifdef YSYX_25040111_CSR_ZEROSKIP_EN
   assign skip = ((op_q == OP_RS) || (op_q == OP_RC)) && (src_q == '0);
`else
   assign skip = 1'b0;
`endif

   // Next state plus the values every registered output takes for the next cycle.
   always_comb begin
      state_d = state_q;
      old_d   = old_q;
      wen_d   = 1'b0;
      ren_d   = 1'b0;
      waddr_d = '0;
      raddr_d = '0;
      wdata_d = '0;
      jtype_d = '0;
      valid_d = out_valid;
      rdata_d = out_rdata;
      redir_d = out_redirect;
      npc_d   = out_npc;
      err_d   = out_err;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               rdata_d = '0;
               redir_d = 1'b0;
               err_d   = 1'b0;
               case (in_op)
                  OP_RW, OP_RS, OP_RC: begin
                     state_d = S_READ;
                     ren_d   = 1'b1;
                     raddr_d = in_addr;
                  end
                  OP_ECALL: begin
                     state_d = S_EPC;
                     wen_d   = 1'b1;
                     waddr_d = A_MEPC;
                     wdata_d = in_pc;
                  end
                  OP_MRET: begin
                     state_d = S_RET;
                     ren_d   = 1'b1;
                     raddr_d = A_MEPC;
                  end
                  default: begin
                     state_d = S_DONE;
                     valid_d = 1'b1;
                     err_d   = 1'b1;
                  end
               endcase
            end
         end
         S_READ: begin
            old_d = csr_rdata;
            if (skip) begin
               state_d = S_DONE;
               valid_d = 1'b1;
               rdata_d = csr_rdata;
            end else begin
               state_d = S_WRITE;
               wen_d   = 1'b1;
               waddr_d = addr_q;
               case (op_q)
                  OP_RS:   wdata_d = csr_rdata | src_q;
                  OP_RC:   wdata_d = csr_rdata & ~src_q;
                  default: wdata_d = src_q;
               endcase
            end
         end
         S_WRITE: begin
            state_d = S_DONE;
            valid_d = 1'b1;
            rdata_d = old_q;
         end
         S_EPC: begin
            // mepc write lands at this edge; the vector fetch and cause record follow
            state_d = S_VEC;
            jtype_d = JT_ECALL;
            ren_d   = 1'b1;
            raddr_d = A_MTVEC;
         end
         S_VEC, S_RET: begin
            state_d = S_DONE;
            npc_d   = csr_rdata;
            redir_d = 1'b1;
            valid_d = 1'b1;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               redir_d = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, operand latches and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         addr_q       <= '0;
         src_q        <= '0;
         pc_q         <= '0;
         old_q        <= '0;
         csr_wen      <= 1'b0;
         csr_ren      <= 1'b0;
         csr_waddr    <= '0;
         csr_raddr    <= '0;
         csr_wdata    <= '0;
         csr_jtype    <= '0;
         out_valid    <= 1'b0;
         out_rdata    <= '0;
         out_redirect <= 1'b0;
         out_npc      <= '0;
         out_err      <= 1'b0;
      end else begin
         state_q      <= state_d;
         old_q        <= old_d;
         csr_wen      <= wen_d;
         csr_ren      <= ren_d;
         csr_waddr    <= waddr_d;
         csr_raddr    <= raddr_d;
         csr_wdata    <= wdata_d;
         csr_jtype    <= jtype_d;
         out_valid    <= valid_d;
         out_rdata    <= rdata_d;
         out_redirect <= redir_d;
         out_npc      <= npc_d;
         out_err      <= err_d;
         if (accept) begin
            op_q   <= in_op;
            addr_q <= in_addr;
            src_q  <= in_src;
            pc_q   <= in_pc;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_25040111_csr_seq.sv
// Bench for ysyx_25040111_csr_seq with a behavioural CSR file and a result scoreboard.
module tb_ysyx_25040111_csr_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [11:0] in_addr;
   logic [31:0] in_src, in_pc;
   logic        csr_wen, csr_ren;
   logic [11:0] csr_waddr, csr_raddr;
   logic [31:0] csr_wdata;
   logic [1:0]  csr_jtype;
   logic [31:0] csr_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rdata;
   logic        out_redirect;
   logic [31:0] out_npc;
   logic        out_err;

   ysyx_25040111_csr_seq dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_addr(in_addr), .in_src(in_src), .in_pc(in_pc),
      .csr_wen(csr_wen), .csr_ren(csr_ren), .csr_waddr(csr_waddr), .csr_raddr(csr_raddr),
      .csr_wdata(csr_wdata), .csr_jtype(csr_jtype), .csr_rdata(csr_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
      .out_redirect(out_redirect), .out_npc(out_npc), .out_err(out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        redirect;
      logic [31:0] npc;
      logic        err;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   lat_got;
   bit   mon_en = 1'b0;
   bit   wen_seen, act_seen, jt_seen;
   logic [11:0] last_waddr;
   logic [31:0] last_wdata;

   // Behavioural CSR file: combinational read, write on the clock edge.
   logic [31:0] m_mstatus = 32'h0000_1800;
   logic [31:0] m_mtvec   = 32'h0;
   logic [31:0] m_mscr    = 32'h0;
   logic [31:0] m_mepc    = 32'h0;
   logic [31:0] m_mcause  = 32'h0;

   always_comb begin
      csr_rdata = 32'h0;
      if (csr_ren === 1'b1) begin
         case (csr_raddr)
            12'h300: csr_rdata = m_mstatus;
            12'h305: csr_rdata = m_mtvec;
            12'h340: csr_rdata = m_mscr;
            12'h341: csr_rdata = m_mepc;
            12'h342: csr_rdata = m_mcause;
            default: csr_rdata = 32'h0;
         endcase
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (csr_wen === 1'b1) begin
         case (csr_waddr)
            12'h300: m_mstatus <= csr_wdata;
            12'h305: m_mtvec   <= csr_wdata;
            12'h340: m_mscr    <= csr_wdata;
            12'h341: m_mepc    <= csr_wdata;
            12'h342: m_mcause  <= csr_wdata;
            default: ;
         endcase
      end
      if (csr_jtype === 2'b01) m_mcause <= 32'd11;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Per-cycle port observation plus the wen/jtype exclusivity rule.
   always @(negedge clk) begin
      if (mon_en) begin
         if (csr_wen === 1'b1 || csr_jtype === 2'b01)
            check("wen_jtype_excl", 32'(csr_wen === 1'b1 && csr_jtype === 2'b01), 32'd0);
         if (csr_wen === 1'b1) begin
            wen_seen   = 1'b1;
            last_waddr = csr_waddr;
            last_wdata = csr_wdata;
         end
         if (csr_jtype === 2'b01) jt_seen = 1'b1;
         if (csr_wen || csr_ren || csr_waddr != 0 || csr_raddr != 0 || csr_wdata != 0 || csr_jtype != 0)
            act_seen = 1'b1;
      end
   end

   task automatic run_op(input string tag, input logic [2:0] op, input logic [11:0] addr,
                         input logic [31:0] src, input logic [31:0] pc, input exp_t e,
                         input int lat, input int stall);
      int a;
      bit ok;
      exp_t x;
      sbq.push_back(e);
      @(negedge clk);
      out_ready = (stall == 0);
      in_valid = 1'b1; in_op = op; in_addr = addr; in_src = src; in_pc = pc;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (in_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) check({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = cyc;
      wen_seen = 1'b0; act_seen = 1'b0; jt_seen = 1'b0;
      last_waddr = '0; last_wdata = '0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1'b1; break; end
      end
      x = sbq.pop_front();
      if (!ok) begin
         check({tag, "_result_timeout"}, 32'(out_valid), 32'd1);
      end else begin
         lat_got = cyc - a + 1;
         check({tag, "_latency"}, 32'(lat_got), 32'(lat));
         check({tag, "_rdata"}, out_rdata, x.rdata);
         check({tag, "_redirect"}, 32'(out_redirect), 32'(x.redirect));
         if (x.redirect) check({tag, "_npc"}, out_npc, x.npc);
         check({tag, "_err"}, 32'(out_err), 32'(x.err));
         for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; in_op = 3'b000; in_addr = 12'h340; in_src = 32'hdead_beef;
            @(negedge clk);
            check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_stall_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_stall_rdata"}, out_rdata, x.rdata);
            check({tag, "_stall_err"}, 32'(out_err), 32'(x.err));
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
         @(posedge clk); #1;
         check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
         check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] rd, input logic rr, input logic [31:0] npc, input logic err);
      exp_t e;
      e.rdata = rd; e.redirect = rr; e.npc = npc; e.err = err;
      return e;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_csr"}, 32'({csr_wen, csr_ren, csr_jtype}), 32'd0);
      check({tag, "_csr_addr"}, 32'({csr_waddr, csr_raddr}), 32'd0);
      check({tag, "_csr_wdata"}, csr_wdata, 32'd0);
      check({tag, "_out_flags"}, 32'({out_valid, out_redirect, out_err}), 32'd0);
      check({tag, "_out_data"}, out_rdata | out_npc, 32'd0);
   endtask

   logic [31:0] ref_scr;
   logic [31:0] rsrc;
   logic [2:0]  rop;
   int zs_lat;

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_op = '0; in_addr = '0; in_src = '0; in_pc = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b1;
      mon_en = 1'b1;

`ifdef YSYX_25040111_CSR_ZEROSKIP_EN
      zs_lat = 2;
`else
      zs_lat = 3;
`endif
      run_op("rs_mstatus", 3'b001, 12'h300, 32'h0, 32'h0, mk(32'h0000_1800, 0, 0, 0), zs_lat, 0);
`ifdef YSYX_25040111_CSR_ZEROSKIP_EN
      check("rs_mstatus_no_wen", 32'(wen_seen), 32'd0);
`else
      check("rs_mstatus_wdata", last_wdata, 32'h0000_1800);
`endif

      run_op("rw_mtvec", 3'b000, 12'h305, 32'h8000_0100, 32'h0, mk(32'h0, 0, 0, 0), 3, 0);
      run_op("rc_mtvec", 3'b010, 12'h305, 32'h0000_0100, 32'h0, mk(32'h8000_0100, 0, 0, 0), 3, 0);
      check("rc_mtvec_waddr", 32'(last_waddr), 32'h305);
      check("rc_mtvec_wdata", last_wdata, 32'h8000_0000);
      run_op("rw_mtvec2", 3'b000, 12'h305, 32'h8000_0100, 32'h0, mk(32'h8000_0000, 0, 0, 0), 3, 0);

      run_op("ecall", 3'b011, 12'h0, 32'h0, 32'h8000_0040, mk(32'h0, 1, 32'h8000_0100, 0), 3, 0);
      check("ecall_epc_waddr", 32'(last_waddr), 32'h341);
      check("ecall_epc_wdata", last_wdata, 32'h8000_0040);
      check("ecall_jtype_seen", 32'(jt_seen), 32'd1);
      run_op("rd_mcause", 3'b001, 12'h342, 32'h0, 32'h0, mk(32'd11, 0, 0, 0), zs_lat, 0);

      run_op("mret", 3'b100, 12'h0, 32'h0, 32'h0, mk(32'h0, 1, 32'h8000_0040, 0), 2, 0);
      check("mret_no_wen", 32'(wen_seen), 32'd0);

      run_op("rs_ro_stall", 3'b001, 12'hF11, 32'h5, 32'h0, mk(32'h0, 0, 0, 0), 3, 5);
      check("rs_ro_waddr", 32'(last_waddr), 32'hF11);
      check("rs_ro_wdata", last_wdata, 32'h5);

      run_op("illegal7", 3'b111, 12'h300, 32'hffff_ffff, 32'h1234, mk(32'h0, 0, 0, 1), 1, 0);
      check("illegal7_no_csr", 32'(act_seen), 32'd0);
      run_op("illegal5", 3'b101, 12'h305, 32'h1, 32'h0, mk(32'h0, 0, 0, 1), 1, 2);
      check("illegal5_no_csr", 32'(act_seen), 32'd0);

      // Reset while in VEC: mepc write already done, sequence abandoned.
      @(negedge clk);
      in_valid = 1'b1; in_op = 3'b011; in_pc = 32'h8000_0080; in_addr = '0; in_src = '0;
      check("rst_vec_accept_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_vec_epc_wen", 32'({csr_wen, csr_waddr}), 32'h1341);
      @(negedge clk);
      check("rst_vec_jtype", 32'(csr_jtype), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("rst_vec");
      reset = 1'b1;
      #1;
      check("rst_vec_ready_release", 32'(in_ready), 32'd1);
      run_op("rd_mepc", 3'b001, 12'h341, 32'h0, 32'h0, mk(32'h8000_0080, 0, 0, 0), zs_lat, 0);

      // Random CSRR* sequence on mscratch against a semantic reference.
      run_op("scr_init", 3'b000, 12'h340, 32'h0f0f_0f0f, 32'h0, mk(32'h0, 0, 0, 0), 3, 0);
      ref_scr = 32'h0f0f_0f0f;
      for (int i = 0; i < 8; i++) begin
         rop  = 3'($urandom_range(0, 2));
         rsrc = (i == 3) ? 32'h0 : $urandom;
         run_op("scr_rand", rop, 12'h340, rsrc, 32'h0, mk(ref_scr, 0, 0, 0),
                (rop != 3'b000 && rsrc == 0) ? zs_lat : 3, 0);
         case (rop)
            3'b000:  ref_scr = rsrc;
            3'b001:  ref_scr = ref_scr | rsrc;
            default: ref_scr = ref_scr & ~rsrc;
         endcase
      end
      run_op("scr_final", 3'b001, 12'h340, 32'h0, 32'h0, mk(ref_scr, 0, 0, 0), zs_lat, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
